// File: rtl/pattern_detector_param.sv
// Programmable streaming pattern detector: PAT_LEN-symbol pattern with per-bit wildcard masks,
// overlapping or non-overlapping matching, sticky request/ack output, match counter and overrun.
module pattern_detector_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IDX_W   = $clog2(PAT_LEN)
) (
  input  logic              clk,
  input  logic              reset_sync,
  input  logic              enable,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              overlap,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic              ack,
  input  logic              clr_stat,
  output logic              found_pattern,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              overrun
);

  localparam int unsigned      FillW    = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

  logic [DATA_W-1:0] pat_q  [PAT_LEN];
  logic [DATA_W-1:0] pat_d  [PAT_LEN];
  logic [DATA_W-1:0] mask_q [PAT_LEN];
  logic [DATA_W-1:0] mask_d [PAT_LEN];
  logic [DATA_W-1:0] hist_q [PAT_LEN];
  logic [DATA_W-1:0] hist_d [PAT_LEN];
  logic [DATA_W-1:0] window [PAT_LEN];

  logic [FillW-1:0] fill_q, fill_d, fill_inc;
  logic             found_q, found_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;

  logic accept;
  logic cfg_hit;
  logic win_eq;
  logic match;

  assign accept  = enable & data_valid;
  assign cfg_hit = cfg_we & (32'(cfg_idx) < PAT_LEN);

  // Window as it will look once the incoming symbol has been shifted in; index 0 is oldest.
  always_comb begin
    for (int i = 0; i < int'(PAT_LEN) - 1; i++) begin
      window[i] = hist_q[i+1];
    end
    window[PAT_LEN-1] = data;
  end

  always_comb begin
    win_eq = 1'b1;
    for (int i = 0; i < int'(PAT_LEN); i++) begin
      if (((window[i] ^ pat_q[i]) & mask_q[i]) != '0) begin
        win_eq = 1'b0;
      end
    end
  end

  assign fill_inc = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);

  // A config write discards any coincident symbol, so it also suppresses matching.
  assign match = accept & ~cfg_hit & (fill_inc == FillFull) & win_eq;

  always_comb begin
    pat_d  = pat_q;
    mask_d = mask_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_hit) begin
      pat_d[cfg_idx]  = cfg_data;
      mask_d[cfg_idx] = cfg_mask;
      fill_d          = '0;
    end else if (accept) begin
      hist_d = window;
      fill_d = (match && !overlap) ? '0 : fill_inc;
    end
  end

  always_comb begin
    found_d   = match | (found_q & ~ack);
    overrun_d = overrun_q | (match & found_q & ~ack);
    cnt_d     = cnt_q;
    if (match && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr_stat) begin
      overrun_d = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      pat_q     <= '{default: '0};
      mask_q    <= '{default: '0};
      hist_q    <= '{default: '0};
      fill_q    <= '0;
      found_q   <= 1'b0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      found_q   <= found_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign found_pattern = found_q;
  assign match_cnt     = cnt_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Self-checking bench for pattern_detector_param: per-cycle scoreboard fed by a queue-based
// reference model, plus spot checks of the documented scenarios.
module tb_pattern_detector_param;

  localparam int PLEN = 4;
  localparam int CMAX = 3;

  logic       clk = 1'b0;
  logic       reset_sync = 1'b0;
  logic       enable = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overlap = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = 2'd0;
  logic [7:0] cfg_data = 8'h00;
  logic [7:0] cfg_mask = 8'h00;
  logic       ack = 1'b0;
  logic       clr_stat = 1'b0;
  logic       found_pattern;
  logic [1:0] match_cnt;
  logic       overrun;

  pattern_detector_param #(
    .DATA_W (8),
    .PAT_LEN(PLEN),
    .CNT_W  (2)
  ) u_dut (
    .clk          (clk),
    .reset_sync   (reset_sync),
    .enable       (enable),
    .data_valid   (data_valid),
    .data         (data),
    .overlap      (overlap),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_data     (cfg_data),
    .cfg_mask     (cfg_mask),
    .ack          (ack),
    .clr_stat     (clr_stat),
    .found_pattern(found_pattern),
    .match_cnt    (match_cnt),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic found;
    int   cnt;
    logic ovr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] win[$];
  logic [7:0] m_pat[PLEN];
  logic [7:0] m_msk[PLEN];
  logic       m_found;
  int         m_cnt;
  logic       m_ovr;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    sb.delete();
    for (int i = 0; i < PLEN; i++) begin
      m_pat[i] = 8'h00;
      m_msk[i] = 8'h00;
    end
    m_found = 1'b0;
    m_cnt   = 0;
    m_ovr   = 1'b0;
  endtask

  // Predict the post-edge outputs from the current inputs, then advance one clock and compare.
  task automatic cycle();
    exp_t e;
    logic mt;
    logic ok;
    mt = 1'b0;
    if (cfg_we && int'(cfg_idx) < PLEN) begin
      m_pat[cfg_idx] = cfg_data;
      m_msk[cfg_idx] = cfg_mask;
      win.delete();
    end else if (enable && data_valid) begin
      win.push_back(data);
      if (win.size() > PLEN) void'(win.pop_front());
      if (win.size() == PLEN) begin
        ok = 1'b1;
        for (int i = 0; i < PLEN; i++) begin
          if (((win[i] ^ m_pat[i]) & m_msk[i]) != 8'h00) ok = 1'b0;
        end
        mt = ok;
        if (ok && !overlap) win.delete();
      end
    end
    if (clr_stat) m_ovr = 1'b0;
    else if (mt && m_found && !ack) m_ovr = 1'b1;
    if (clr_stat) m_cnt = 0;
    else if (mt && m_cnt < CMAX) m_cnt++;
    m_found = mt || (m_found && !ack);
    e = '{found: m_found, cnt: m_cnt, ovr: m_ovr};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_found", {31'd0, found_pattern}, {31'd0, e.found});
    check("sb_cnt", {30'd0, match_cnt}, e.cnt);
    check("sb_overrun", {31'd0, overrun}, {31'd0, e.ovr});
  endtask

  task automatic send(input logic [7:0] d);
    enable     = 1'b1;
    data_valid = 1'b1;
    data       = d;
    cycle();
    data_valid = 1'b0;
  endtask

  task automatic junk(input logic [7:0] d);
    enable     = 1'b0;
    data_valid = 1'b1;
    data       = d;
    cycle();
    data_valid = 1'b0;
    enable     = 1'b1;
  endtask

  task automatic cfg(input int idx, input logic [7:0] d, input logic [7:0] m);
    cfg_we   = 1'b1;
    cfg_idx  = idx[1:0];
    cfg_data = d;
    cfg_mask = m;
    cycle();
    cfg_we = 1'b0;
  endtask

  // Slot 0 sits in p[31:24]; every slot compares fully except slot 2, which uses m2.
  task automatic load(input logic [31:0] p, input logic [7:0] m2);
    for (int i = 0; i < PLEN; i++) begin
      cfg(i, p[31-8*i -: 8], (i == 2) ? m2 : 8'hFF);
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_stat = 1'b1;
    cycle();
    clr_stat = 1'b0;
  endtask

  task automatic send4(input logic [31:0] s);
    for (int i = 0; i < 4; i++) send(s[31-8*i -: 8]);
  endtask

  task automatic do_reset();
    reset_sync = 1'b0;
    #2;
    check("rst_found", {31'd0, found_pattern}, 32'd0);
    check("rst_cnt", {30'd0, match_cnt}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_found", {31'd0, found_pattern}, 32'd0);
    reset_sync = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Exact match, then ack clears the request on the next edge.
    load(32'h626F6D62, 8'hFF);
    overlap = 1'b1;
    send(8'h62); send(8'h6F); send(8'h6D);
    check("bomb_early", {31'd0, found_pattern}, 32'd0);
    send(8'h62);
    check("bomb_found", {31'd0, found_pattern}, 32'd1);
    check("bomb_cnt", {30'd0, match_cnt}, 32'd1);
    ack_pulse();
    check("bomb_ack", {31'd0, found_pattern}, 32'd0);

    // Periodic pattern, overlapping: two matches in six symbols, second one overruns.
    clr_pulse();
    load(32'h626F626F, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      send(8'h62); send(8'h6F);
    end
    check("bobo_ovl_cnt", {30'd0, match_cnt}, 32'd2);
    check("bobo_ovl_ovr", {31'd0, overrun}, 32'd1);
    ack_pulse();
    clr_pulse();

    // Same stream, non-overlapping: only one match.
    overlap = 1'b0;
    load(32'h626F626F, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      send(8'h62); send(8'h6F);
    end
    check("bobo_novl_cnt", {30'd0, match_cnt}, 32'd1);
    check("bobo_novl_ovr", {31'd0, overrun}, 32'd0);
    ack_pulse();
    clr_pulse();

    // Wildcard slot and case-insensitive slot.
    load(32'h626F6D62, 8'h00);
    send4(32'h626F4162);
    check("wild_found", {31'd0, found_pattern}, 32'd1);
    ack_pulse();
    load(32'h626F6D62, 8'hDF);
    send4(32'h626F4D62);
    check("case_found", {31'd0, found_pattern}, 32'd1);
    ack_pulse();
    send4(32'h626F4E62);
    check("case_miss", {31'd0, found_pattern}, 32'd0);
    clr_pulse();

    // Reset mid-stream with a request pending aborts everything.
    load(32'h626F6D62, 8'hFF);
    send4(32'h626F6D62);
    send(8'h62); send(8'h6F); send(8'h6D);
    do_reset();
    send(8'h62);
    check("post_rst_found", {31'd0, found_pattern}, 32'd0);
    check("post_rst_cnt", {30'd0, match_cnt}, 32'd0);

    // Gaps and disabled junk do not disturb the partial match.
    load(32'h626F6D62, 8'hFF);
    send(8'h62); cycle(); junk(8'h00); junk(8'h6D);
    send(8'h6F); junk(8'h55); send(8'h6D); cycle();
    send(8'h62);
    check("gap_found", {31'd0, found_pattern}, 32'd1);
    ack_pulse();

    // A config write resynchronises the stream.
    send(8'h62); send(8'h6F);
    cfg(0, 8'h62, 8'hFF);
    send(8'h6D); send(8'h62);
    check("cfg_resync", {31'd0, found_pattern}, 32'd0);
    send4(32'h626F6D62);
    check("cfg_resync_found", {31'd0, found_pattern}, 32'd1);
    ack_pulse();

    // Config write coincident with a symbol discards the symbol.
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = 8'h62; cfg_mask = 8'hFF;
    data_valid = 1'b1; data = 8'h62;
    cycle();
    cfg_we = 1'b0; data_valid = 1'b0;
    send(8'h6F); send(8'h6D); send(8'h62);
    check("cfg_coinc", {31'd0, found_pattern}, 32'd0);
    send4(32'h626F6D62);
    check("cfg_coinc_found", {31'd0, found_pattern}, 32'd1);
    ack_pulse();

    // Saturation with ack held high, then clear coincident with a match.
    overlap = 1'b1;
    clr_pulse();
    load(32'h626F626F, 8'hFF);
    ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(8'h62); send(8'h6F);
    end
    check("sat_cnt", {30'd0, match_cnt}, 32'd3);
    check("sat_ovr", {31'd0, overrun}, 32'd0);
    cycle();
    ack = 1'b0;
    send(8'h62);
    clr_stat = 1'b1;
    send(8'h6F);
    clr_stat = 1'b0;
    check("clr_match_cnt", {30'd0, match_cnt}, 32'd0);
    check("clr_match_found", {31'd0, found_pattern}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
